// File: rtl/conv_pkg.sv
// Shared constants, types and helpers for the conv window scheduler.
package conv_pkg;

  localparam int CONV_WIDTH = 8;
  localparam int CONV_F     = 5;
  localparam int CONV_CIN   = 3;
  localparam int CONV_ZW    = CONV_WIDTH * 2 + $clog2(CONV_CIN * CONV_F * CONV_F);

  typedef logic [CONV_WIDTH*CONV_CIN-1:0] pix_t;
  typedef logic [CONV_CIN*CONV_F*CONV_F-1:0][CONV_WIDTH-1:0] win_t;

  // Flat position of a window element: channel-major, then row (top first), then column (left first).
  function automatic int win_idx(input int c, input int ky, input int kx);
    return c * CONV_F * CONV_F + ky * CONV_F + kx;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Line buffer holding the F-1 most recent image rows for the window scheduler.
// Rows live in a circular set of slots; r_ptr names the slot of the oldest row,
// which is also the slot the incoming pixel overwrites.
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int WIDTH = CONV_WIDTH,
  parameter int CIN   = CONV_CIN,
  parameter int F     = CONV_F,
  parameter int IMG_W = 32,
  localparam int PW   = WIDTH * CIN,
  localparam int CW   = $clog2(IMG_W),
  localparam int NR   = F - 1,
  localparam int PTRW = (NR > 1) ? $clog2(NR) : 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic               row_adv,
  input  logic [CW-1:0]      col,
  input  logic [PW-1:0]      wdata,
  output logic [NR*PW-1:0]   taps
);

  logic [PTRW-1:0] r_ptr;
  logic [PW-1:0]   r_mem [NR][IMG_W];
  logic [PTRW-1:0] w_slot [NR];

  // Advance the oldest-row pointer each time a full row has been written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= {PTRW{1'b0}};
    end else if (clr) begin
      r_ptr <= {PTRW{1'b0}};
    end else if (row_adv) begin
      if (r_ptr == PTRW'(NR - 1)) begin
        r_ptr <= {PTRW{1'b0}};
      end else begin
        r_ptr <= r_ptr + PTRW'(1);
      end
    end
  end

  // Store the accepted pixel over the oldest row at the current column (contents never cleared).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[r_ptr][col] <= wdata;
    end
  end

  // Map tap k (window row k, oldest first) onto its circular slot.
  always_comb begin
    for (int k = 0; k < NR; k++) begin
      if (int'(r_ptr) + k >= NR) begin
        w_slot[k] = PTRW'(int'(r_ptr) + k - NR);
      end else begin
        w_slot[k] = PTRW'(int'(r_ptr) + k);
      end
    end
  end

  // Read every buffered row at the current column in the same cycle (pre-write data).
  for (genvar k = 0; k < NR; k++) begin : g_tap
    assign taps[k*PW +: PW] = r_mem[w_slot[k]][col];
  end

endmodule

// File: rtl/conv_window_sched.sv
// Streaming FxFxCIN window scheduler in front of a combinational conv layer.
// Tracks the raster position, shifts the window one column per accepted beat,
// and hands the layer result downstream through a valid/ready slot.
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int WIDTH = CONV_WIDTH,
  parameter int F     = CONV_F,
  parameter int CIN   = CONV_CIN,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  localparam int ZW   = WIDTH * 2 + $clog2(CIN * F * F),
  localparam int NW   = CIN * F * F,
  localparam int PW   = WIDTH * CIN,
  localparam int RW   = $clog2(IMG_H),
  localparam int CW   = $clog2(IMG_W)
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                soft_clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PW-1:0]       in_pix,
  output logic [NW*WIDTH-1:0] win_x,
  input  logic [ZW-1:0]       layer_z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ZW-1:0]       out_z,
  output logic [RW-1:0]       out_row,
  output logic [CW-1:0]       out_col,
  output logic                out_last,
  output logic                frame_done
);

  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [NW*WIDTH-1:0] r_win;
  logic                r_out_valid;
  logic [RW-1:0]       r_out_row;
  logic [CW-1:0]       r_out_col;
  logic                r_out_last;
  logic                r_frame_done;

  logic                w_accept;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_qualify;
  logic [(F-1)*PW-1:0] w_taps;
  logic [NW*WIDTH-1:0] w_win_nxt;

  // A beat can enter only when the result slot is free or being drained; a clear drops the beat.
  assign in_ready   = !soft_clr && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_col_last = (r_col == CW'(IMG_W - 1));
  assign w_row_last = (r_row == RW'(IMG_H - 1));
  assign w_qualify  = w_accept && (r_row >= RW'(F - 1)) && (r_col >= CW'(F - 1));

  conv_line_buf #(
    .WIDTH (WIDTH),
    .CIN   (CIN),
    .F     (F),
    .IMG_W (IMG_W)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (soft_clr),
    .wr_en   (w_accept),
    .row_adv (w_accept && w_col_last),
    .col     (r_col),
    .wdata   (in_pix),
    .taps    (w_taps)
  );

  // Next window: shift every row left one column and fill the right column from the taps and the new pixel.
  always_comb begin
    w_win_nxt = r_win;
    for (int c = 0; c < CIN; c++) begin
      for (int ky = 0; ky < F; ky++) begin
        for (int kx = 0; kx < F - 1; kx++) begin
          w_win_nxt[((c*F + ky)*F + kx)*WIDTH +: WIDTH] = r_win[((c*F + ky)*F + kx + 1)*WIDTH +: WIDTH];
        end
        if (ky < F - 1) begin
          w_win_nxt[((c*F + ky)*F + F - 1)*WIDTH +: WIDTH] = w_taps[ky*PW + c*WIDTH +: WIDTH];
        end else begin
          w_win_nxt[((c*F + ky)*F + F - 1)*WIDTH +: WIDTH] = in_pix[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Raster position counters with row and frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= {RW{1'b0}};
      r_col <= {CW{1'b0}};
    end else if (soft_clr) begin
      r_row <= {RW{1'b0}};
      r_col <= {CW{1'b0}};
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= {CW{1'b0}};
        if (w_row_last) begin
          r_row <= {RW{1'b0}};
        end else begin
          r_row <= r_row + RW'(1);
        end
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  // Window shift register; frozen whenever no beat is accepted (including stalls).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win <= {(NW*WIDTH){1'b0}};
    end else if (soft_clr) begin
      r_win <= {(NW*WIDTH){1'b0}};
    end else if (w_accept) begin
      r_win <= w_win_nxt;
    end
  end

  // Result slot: load on a qualifying beat, drop on consumption, otherwise hold everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_row    <= {RW{1'b0}};
      r_out_col    <= {CW{1'b0}};
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (soft_clr) begin
      r_out_valid  <= 1'b0;
      r_out_row    <= {RW{1'b0}};
      r_out_col    <= {CW{1'b0}};
      r_out_last   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_col_last && w_row_last;
      if (w_qualify) begin
        r_out_valid <= 1'b1;
        r_out_row   <= r_row - RW'(F - 1);
        r_out_col   <= r_col - CW'(F - 1);
        r_out_last  <= w_row_last && w_col_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign win_x      = r_win;
  assign out_valid  = r_out_valid;
  assign out_z      = layer_z;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign out_last   = r_out_last;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_conv_window_sched.sv
// Self-checking bench for conv_window_sched on an 8x8 image, F=5, CIN=3.
module tb_conv_window_sched;

  localparam int W  = 8;
  localparam int FF = 5;
  localparam int CI = 3;
  localparam int IW = 8;
  localparam int IH = 8;
  localparam int NW = CI * FF * FF;
  localparam int ZW = W * 2 + $clog2(NW);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              soft_clr = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W*CI-1:0]   in_pix = '0;
  logic [NW*W-1:0]   win_x;
  logic [ZW-1:0]     layer_z;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ZW-1:0]     out_z;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_last;
  logic              frame_done;

  conv_window_sched #(.WIDTH(W), .F(FF), .CIN(CI), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .soft_clr(soft_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .win_x(win_x), .layer_z(layer_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Layer model: sum of every window element.
  always_comb begin
    layer_z = '0;
    for (int i = 0; i < NW; i++) layer_z += ZW'(win_x[i*W +: W]);
  end

  typedef struct packed {
    logic [ZW-1:0]   z;
    logic [2:0]      row;
    logic [2:0]      col;
    logic            last;
    logic [NW*W-1:0] win;
  } exp_t;

  typedef struct {
    int pat;
    int stall_pct;
    int bubble_pct;
    int stall_at;
    int exp_res;
    int exp_fd;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  exp_t        q[$];
  logic [23:0] img [IH][IW];
  int          m_r = 0, m_c = 0;
  logic        fd_exp = 1'b0;
  int          n_res = 0, n_fd = 0;
  logic [ZW-1:0] first_z;
  logic [2:0]  first_row, first_col;
  logic [7:0]  first_x38;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: store the frame as an image and derive each window directly from its coordinates.
  task automatic model_accept(input logic [23:0] pix);
    exp_t e;
    int   z, v;
    img[m_r][m_c] = pix;
    if (m_r >= FF - 1 && m_c >= FF - 1) begin
      e.win = '0;
      z = 0;
      for (int ch = 0; ch < CI; ch++)
        for (int ky = 0; ky < FF; ky++)
          for (int kx = 0; kx < FF; kx++) begin
            v = int'(img[m_r-FF+1+ky][m_c-FF+1+kx][ch*W +: W]);
            e.win[conv_pkg::win_idx(ch, ky, kx)*W +: W] = 8'(v);
            z += v;
          end
      e.z    = ZW'(z);
      e.row  = 3'(m_r - FF + 1);
      e.col  = 3'(m_c - FF + 1);
      e.last = (m_r == IH - 1) && (m_c == IW - 1);
      q.push_back(e);
    end
    if (m_r == IH - 1 && m_c == IW - 1) fd_exp = 1'b1;
    if (m_c == IW - 1) begin
      m_c = 0;
      m_r = (m_r == IH - 1) ? 0 : m_r + 1;
    end else begin
      m_c++;
    end
  endtask

  // Monitor: compares the result slot against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst || soft_clr) begin
      q.delete();
      m_r = 0;
      m_c = 0;
      fd_exp = 1'b0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_z", 64'(out_z), 64'(q[0].z));
        chk("out_row", 64'(out_row), 64'(q[0].row));
        chk("out_col", 64'(out_col), 64'(q[0].col));
        chk("out_last", 64'(out_last), 64'(q[0].last));
        n_cmp++;
        if (win_x !== q[0].win) begin
          n_fail++;
          $display("FAIL win_x: got %h expected %h", win_x, q[0].win);
        end
        if (out_ready) begin
          if (n_res == 0) begin
            first_z   = out_z;
            first_row = out_row;
            first_col = out_col;
            first_x38 = win_x[conv_pkg::win_idx(2, 4, 4)*W +: W];
          end
          n_res++;
          void'(q.pop_front());
        end
      end
      chk("frame_done", 64'(frame_done), 64'(fd_exp));
      if (frame_done) n_fd++;
      fd_exp = 1'b0;
      if (in_valid && in_ready) model_accept(in_pix);
    end
  end

  function automatic logic [23:0] pixval(input int pat, input int r, input int c);
    logic [23:0] p;
    p = 24'd0;
    for (int ch = 0; ch < CI; ch++) begin
      case (pat)
        0:       p[ch*W +: W] = 8'd1;
        1:       p[ch*W +: W] = 8'(r * IW + c + ch);
        default: p[ch*W +: W] = 8'($urandom_range(255));
      endcase
    end
    return p;
  endfunction

  // Drive one frame; optionally stall 10 cycles, hard-reset or soft-clear after a given beat count.
  task automatic run_frame(input int pat, input int stall_pct, input int bubble_pct,
                           input int stall_at, input int abort_at, input int sclr_at,
                           input int exp_res, input int exp_fd);
    int acc = 0, r = 0, c = 0, guard = 0;
    bit stalled = 0, cut = 0;
    n_res = 0;
    n_fd  = 0;
    while (acc < IW * IH && guard < 3000 && !cut) begin
      guard++;
      @(posedge clk); #1;
      if (acc == abort_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        chk("rst_out_col", 64'(out_col), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cut = 1;
      end else if (acc == sclr_at) begin
        soft_clr = 1'b1;
        in_valid = 1'b1;
        in_pix   = pixval(pat, r, c);
        @(negedge clk);
        chk("sclr_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        soft_clr = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("sclr_out_valid", 64'(out_valid), 64'd0);
        chk("sclr_out_row", 64'(out_row), 64'd0);
        cut = 1;
      end else begin
        if (acc == stall_at && !stalled) begin
          stalled   = 1;
          out_ready = 1'b0;
          in_valid  = 1'b1;
          in_pix    = pixval(pat, r, c);
          for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
          end
        end
        out_ready = ($urandom_range(99) >= stall_pct);
        in_valid  = ($urandom_range(99) >= bubble_pct);
        in_pix    = pixval(pat, r, c);
        @(negedge clk);
        if (in_valid && in_ready) begin
          acc++;
          if (c == IW - 1) begin
            c = 0;
            r++;
          end else begin
            c++;
          end
        end
      end
    end
    if (!cut) begin
      chk("accept_timeout", 64'(acc), 64'(IW * IH));
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      guard = 0;
      while ((out_valid || q.size() != 0) && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("drain_timeout", 64'(out_valid), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("n_results", 64'(n_res), 64'(exp_res));
      chk("n_frame_done", 64'(n_fd), 64'(exp_fd));
    end
  endtask

  vec_t tbl [6];

  initial begin
    //                pat stall bubble stall_at results frame_done
    tbl[0] = '{0,   0,    0,    -1,      16,     1};
    tbl[1] = '{1,   0,    0,    -1,      16,     1};
    tbl[2] = '{0,   0,    0,    45,      16,     1};
    tbl[3] = '{2,  30,   20,    -1,      16,     1};
    tbl[4] = '{1,  50,   40,    -1,      16,     1};
    tbl[5] = '{2,   0,    0,    -1,      16,     1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_last", 64'(out_last), 64'd0);
    chk("reset_frame_done", 64'(frame_done), 64'd0);
    chk("reset_out_row", 64'(out_row), 64'd0);
    chk("reset_out_col", 64'(out_col), 64'd0);
    chk("reset_win_zero", 64'(win_x == '0), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Back-to-back frames from the table; no reset in between, so stale rows stay in the buffer.
    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].pat, tbl[i].stall_pct, tbl[i].bubble_pct, tbl[i].stall_at, -1, -1,
                tbl[i].exp_res, tbl[i].exp_fd);
      if (tbl[i].pat == 0) begin
        chk("ones_first_z", 64'(first_z), 64'd75);
        chk("ones_first_row", 64'(first_row), 64'd0);
        chk("ones_first_col", 64'(first_col), 64'd0);
      end
      if (tbl[i].pat == 1) chk("ramp_x_2_4_4", 64'(first_x38), 64'd38);
    end

    // Hard reset mid-frame (before and while a result is pending), then full frames.
    run_frame(2, 0, 0, -1, 20, -1, 0, 0);
    run_frame(0, 0, 0, -1, -1, -1, 16, 1);
    chk("post_rst_first_z", 64'(first_z), 64'd75);
    run_frame(1, 0, 0, -1, 39, -1, 0, 0);
    run_frame(2, 20, 10, -1, -1, -1, 16, 1);

    // Soft clear coinciding with a valid beat while a result is pending.
    run_frame(2, 0, 0, -1, -1, 40, 0, 0);
    run_frame(1, 0, 0, -1, -1, -1, 16, 1);
    chk("post_sclr_x_2_4_4", 64'(first_x38), 64'd38);
    chk("post_sclr_first_row", 64'(first_row), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
